// File: rtl/user_tag_generator_if.sv
// Tag stream bundle: per-lane tag time, channel and edge, with a contiguous lane-valid mask.
interface user_tag_generator_if #(
  parameter int unsigned WORD_WIDTH = 4
);
  logic                        tvalid;
  logic                        tready;
  logic [WORD_WIDTH-1:0][63:0] tagtime;
  logic [WORD_WIDTH-1:0][4:0]  channel;
  logic [WORD_WIDTH-1:0]       rising_edge;
  logic [WORD_WIDTH-1:0]       tkeep;

  modport master (output tvalid, tagtime, channel, rising_edge, tkeep, input tready);
  modport slave  (input tvalid, tagtime, channel, rising_edge, tkeep, output tready);
endinterface

// File: rtl/user_tag_generator.sv
// Synthetic periodic pulse-train tag source, W time-sorted tags per beat.
// Optional pseudo-random pulse offset enabled by defining TAG_GEN_JITTER_EN.
module user_tag_generator #(
  parameter int unsigned WORD_WIDTH  = 4,
  parameter int unsigned JITTER_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  cfg_channel,
  input  logic [63:0] cfg_start_time,
  input  logic [63:0] cfg_period,
  input  logic [63:0] cfg_high_time,
  input  logic [31:0] cfg_count,
  input  logic [15:0] cfg_seed,
  output logic        busy,
  output logic        done,
  output logic        cfg_error,
  user_tag_generator_if.master m_axis
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t      state, state_next;
  logic [4:0]  ch_q;
  logic [63:0] period_q, high_q;
  logic        bounded_q;
  logic [31:0] remaining_q;
  logic        fall_pending_q;
  logic [63:0] next_rise_q, rise_t_q, off_q;
  logic        cfg_ok;

`ifdef TAG_GEN_JITTER_EN
  logic [15:0] lfsr_q, lfsr_c;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  assign cfg_ok = (cfg_high_time != '0) && (cfg_high_time < cfg_period) &&
                  ({1'b0, cfg_period} > ({1'b0, cfg_high_time} + (65'd1 << JITTER_BITS)));
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_seed, 1'(JITTER_BITS)};
  assign cfg_ok = (cfg_high_time != '0) && (cfg_high_time < cfg_period);
`endif

  // Beat builder: walks the event sequence lane by lane from the registered cursor.
  logic [WORD_WIDTH-1:0][63:0] b_time, f_time;
  logic [WORD_WIDTH-1:0]       b_rise, b_keep;
  logic                        c_fall;
  logic [63:0]                 c_next, c_rise, c_off;
  logic [31:0]                 c_rem;
  logic                        will_end;

  always_comb begin
    b_time = '0;
    b_rise = '0;
    b_keep = '0;
    c_fall = fall_pending_q;
    c_next = next_rise_q;
    c_rise = rise_t_q;
    c_off  = off_q;
    c_rem  = remaining_q;
`ifdef TAG_GEN_JITTER_EN
    lfsr_c = lfsr_q;
`endif
    for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
      if (!(bounded_q && c_rem == '0)) begin
        b_keep[i] = 1'b1;
        if (!c_fall) begin
`ifdef TAG_GEN_JITTER_EN
          c_off  = 64'(lfsr_c[JITTER_BITS-1:0]);
          lfsr_c = lfsr_step(lfsr_c);
`endif
          b_time[i] = c_next + c_off;
          b_rise[i] = 1'b1;
          c_rise    = c_next;
          c_fall    = 1'b1;
        end else begin
          b_time[i] = c_rise + high_q + c_off;
          c_next    = c_rise + period_q;
          c_fall    = 1'b0;
          if (bounded_q) c_rem = c_rem - 32'd1;
        end
      end
    end
    will_end  = bounded_q && (c_rem == '0);
    f_time    = '0;
    f_time[0] = rise_t_q + high_q + off_q;
  end

  logic fire, free;
  logic load_beat, load_flush, accept, reject, done_next;

  assign fire = m_axis.tvalid && m_axis.tready;
  assign free = !m_axis.tvalid || m_axis.tready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Count exhaustion outranks stop: the final beat is loaded even if stop arrives with it.
  always_comb begin
    state_next = state;
    load_beat  = 1'b0;
    load_flush = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept     = 1'b1;
            state_next = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        if (free && will_end) begin
          load_beat  = 1'b1;
          state_next = DRAIN;
        end else if (stop) begin
          if (fall_pending_q) begin
            if (free) begin
              load_flush = 1'b1;
              state_next = DRAIN;
            end else begin
              state_next = FLUSH;
            end
          end else if (free) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end else if (free) begin
          load_beat = 1'b1;
        end
      end
      FLUSH: begin
        if (free) begin
          load_flush = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (free) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done               <= 1'b0;
      cfg_error          <= 1'b0;
      ch_q               <= '0;
      period_q           <= '0;
      high_q             <= '0;
      bounded_q          <= 1'b0;
      remaining_q        <= '0;
      fall_pending_q     <= 1'b0;
      next_rise_q        <= '0;
      rise_t_q           <= '0;
      off_q              <= '0;
`ifdef TAG_GEN_JITTER_EN
      lfsr_q             <= 16'h0001;
`endif
      m_axis.tvalid      <= 1'b0;
      m_axis.tagtime     <= '0;
      m_axis.channel     <= '0;
      m_axis.rising_edge <= '0;
      m_axis.tkeep       <= '0;
    end else begin
      done <= done_next;
      if (reject) cfg_error <= 1'b1;
      if (accept) begin
        cfg_error      <= 1'b0;
        ch_q           <= cfg_channel;
        period_q       <= cfg_period;
        high_q         <= cfg_high_time;
        bounded_q      <= (cfg_count != '0);
        remaining_q    <= cfg_count;
        fall_pending_q <= 1'b0;
        next_rise_q    <= cfg_start_time;
        rise_t_q       <= cfg_start_time;
        off_q          <= '0;
`ifdef TAG_GEN_JITTER_EN
        lfsr_q         <= (cfg_seed == '0) ? 16'h0001 : cfg_seed;
`endif
      end
      if (load_beat) begin
        m_axis.tvalid      <= 1'b1;
        m_axis.tagtime     <= b_time;
        m_axis.rising_edge <= b_rise;
        m_axis.tkeep       <= b_keep;
        for (int unsigned i = 0; i < WORD_WIDTH; i++)
          m_axis.channel[i] <= b_keep[i] ? ch_q : '0;
        fall_pending_q <= c_fall;
        next_rise_q    <= c_next;
        rise_t_q       <= c_rise;
        off_q          <= c_off;
        remaining_q    <= c_rem;
`ifdef TAG_GEN_JITTER_EN
        lfsr_q         <= lfsr_c;
`endif
      end else if (load_flush) begin
        m_axis.tvalid      <= 1'b1;
        m_axis.tagtime     <= f_time;
        m_axis.rising_edge <= '0;
        m_axis.tkeep       <= WORD_WIDTH'(1);
        m_axis.channel     <= '0;
        m_axis.channel[0]  <= ch_q;
        fall_pending_q     <= 1'b0;
      end else if (fire) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_user_tag_generator.sv
// Bench for user_tag_generator: W=4 and W=3 instances, tag lists modelled from the pulse-train rules.
module tb_user_tag_generator;
  localparam int unsigned JB = 8;
`ifdef TAG_GEN_JITTER_EN
  localparam logic [63:0] BASE_PERIOD = 64'd600;
  localparam logic [63:0] WRAP_PERIOD = 64'd400;
`else
  localparam logic [63:0] BASE_PERIOD = 64'd300;
  localparam logic [63:0] WRAP_PERIOD = 64'd100;
`endif

  typedef struct packed {
    logic [63:0] t;
    logic        r;
  } tag_t;

  logic        clk, rst_n, start, stop, tready;
  logic [4:0]  cfg_channel;
  logic [63:0] cfg_start_time, cfg_period, cfg_high_time;
  logic [31:0] cfg_count;
  logic [15:0] cfg_seed;
  logic        busy4, done4, err4, busy3, done3, err3;

  user_tag_generator_if #(.WORD_WIDTH(4)) axis4 ();
  user_tag_generator_if #(.WORD_WIDTH(3)) axis3 ();
  assign axis4.tready = tready;
  assign axis3.tready = tready;

  user_tag_generator #(.WORD_WIDTH(4), .JITTER_BITS(JB)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_channel(cfg_channel),
    .cfg_start_time(cfg_start_time), .cfg_period(cfg_period), .cfg_high_time(cfg_high_time),
    .cfg_count(cfg_count), .cfg_seed(cfg_seed), .busy(busy4), .done(done4),
    .cfg_error(err4), .m_axis(axis4));

  user_tag_generator #(.WORD_WIDTH(3), .JITTER_BITS(JB)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_channel(cfg_channel),
    .cfg_start_time(cfg_start_time), .cfg_period(cfg_period), .cfg_high_time(cfg_high_time),
    .cfg_count(cfg_count), .cfg_seed(cfg_seed), .busy(busy3), .done(done3),
    .cfg_error(err3), .m_axis(axis3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int sel = 4;

  logic            obs_valid, obs_busy, obs_done, obs_err;
  logic [3:0]      obs_keep, obs_rise;
  logic [3:0][63:0] obs_time;
  logic [3:0][4:0] obs_chan;

  always_comb begin
    if (sel == 3) begin
      obs_valid = axis3.tvalid;  obs_keep = {1'b0, axis3.tkeep};
      obs_rise  = {1'b0, axis3.rising_edge};
      obs_time  = {64'h0, axis3.tagtime};  obs_chan = {5'h0, axis3.channel};
      obs_busy  = busy3;  obs_done = done3;  obs_err = err3;
    end else begin
      obs_valid = axis4.tvalid;  obs_keep = axis4.tkeep;  obs_rise = axis4.rising_edge;
      obs_time  = axis4.tagtime; obs_chan = axis4.channel;
      obs_busy  = busy4;  obs_done = done4;  obs_err = err4;
    end
  end

  tag_t       exp_q[$], got_q[$];
  logic [4:0] got_ch_q[$];
  logic [3:0] keep_q[$];
  logic [4:0] exp_ch;
  int first_valid_it, last_acc_it, done_it, held_bad;

  // Pulse k rises at start + k*period (+offset k) and falls high_time later.
  task automatic build_expected(input logic [63:0] st, input logic [63:0] per,
                                input logic [63:0] hi, input int unsigned cnt,
                                input logic [15:0] seed);
    logic [63:0] base, off;
`ifdef TAG_GEN_JITTER_EN
    logic [15:0] l;
    l = (seed == 16'h0) ? 16'h0001 : seed;
`endif
    exp_q.delete();
    for (int unsigned k = 0; k < cnt; k++) begin
      base = st + 64'(k) * per;
`ifdef TAG_GEN_JITTER_EN
      off = 64'(l[JB-1:0]);
      l   = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
`else
      off = 64'(seed) & 64'h0;
`endif
      exp_q.push_back(tag_t'{base + off, 1'b1});
      exp_q.push_back(tag_t'{base + hi + off, 1'b0});
    end
  endtask

  function automatic logic [3:0] keep_for(input int b);
    int n;
    n = exp_q.size() - b * sel;
    if (n > sel) n = sel;
    if (n < 0) n = 0;
    return 4'((1 << n) - 1);
  endfunction

  task automatic set_cfg(input logic [4:0] ch, input logic [63:0] st, input logic [63:0] per,
                         input logic [63:0] hi, input logic [31:0] cnt, input logic [15:0] seed);
    cfg_channel = ch; cfg_start_time = st; cfg_period = per;
    cfg_high_time = hi; cfg_count = cnt; cfg_seed = seed; exp_ch = ch;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records accepted beats; mode 0 tready=1, 1 random stalls, 2 stall first 5 valid cycles.
  task automatic collect(input int mode, input int budget);
    int stall_left;
    logic prev_stalled;
    logic [3:0] s_keep, s_rise;
    logic [3:0][63:0] s_time;
    logic [3:0][4:0] s_chan;
    got_q.delete(); got_ch_q.delete(); keep_q.delete();
    first_valid_it = -1; last_acc_it = -1; done_it = -1; held_bad = 0;
    stall_left = (mode == 2) ? 5 : 0;
    prev_stalled = 1'b0;
    s_keep = '0; s_rise = '0; s_time = '0; s_chan = '0;
    for (int it = 0; it < budget; it++) begin
      if (prev_stalled && (obs_valid !== 1'b1 || obs_time !== s_time || obs_keep !== s_keep ||
                           obs_rise !== s_rise || obs_chan !== s_chan))
        held_bad++;
      if (obs_done === 1'b1) begin
        done_it = it;
        break;
      end
      if (mode == 1) tready = ($urandom_range(0, 99) >= 30);
      else if (mode == 2 && obs_valid && stall_left > 0) begin
        tready = 1'b0;
        stall_left--;
      end else tready = 1'b1;
      if (obs_valid && first_valid_it < 0) first_valid_it = it;
      if (obs_valid && tready) begin
        last_acc_it = it;
        keep_q.push_back(obs_keep);
        for (int l = 0; l < 4; l++)
          if (obs_keep[l]) begin
            got_q.push_back(tag_t'{obs_time[l], obs_rise[l]});
            got_ch_q.push_back(obs_chan[l]);
          end
      end
      prev_stalled = obs_valid && !tready;
      s_keep = obs_keep; s_rise = obs_rise; s_time = obs_time; s_chan = obs_chan;
      @(negedge clk);
    end
    tready = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b0;
    set_cfg(5'd0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    for (int s = 3; s <= 4; s++) begin
      sel = s;
      #1;
      n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid w%0d got=%b exp=0", s, obs_valid); end
      n_cmp++; if (obs_keep !== 4'h0) begin n_bad++; $display("FAIL reset_tkeep w%0d got=%h exp=0", s, obs_keep); end
      n_cmp++; if (obs_time[0] !== 64'h0 || obs_rise !== 4'h0 || obs_chan[0] !== 5'h0) begin
        n_bad++; $display("FAIL reset_data w%0d got=%h/%h/%h exp=0", s, obs_time[0], obs_rise, obs_chan[0]); end
      n_cmp++; if ({obs_busy, obs_done, obs_err} !== 3'b000) begin
        n_bad++; $display("FAIL reset_status w%0d got=%b exp=000", s, {obs_busy, obs_done, obs_err}); end
    end
    @(negedge clk);
    rst_n = 1'b1; tready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    sel = 4;
    set_cfg(5'd3, 64'd1000, BASE_PERIOD, 64'd100, 32'd3, 16'd1);
    build_expected(64'd1000, BASE_PERIOD, 64'd100, 3, 16'd1);
    pulse_start();
    collect(0, 60);
    n_cmp++; if (first_valid_it !== 1) begin n_bad++; $display("FAIL basic_latency got=%0d exp=1", first_valid_it); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL basic_tag%0d got=%0d/%b/ch%0d exp=%0d/%b/ch%0d", i, got_q[i].t, got_q[i].r, got_ch_q[i], exp_q[i].t, exp_q[i].r, exp_ch); end
    end
    for (int b = 0; b < keep_q.size(); b++) begin
      n_cmp++; if (keep_q[b] !== keep_for(b)) begin n_bad++; $display("FAIL basic_tkeep%0d got=%b exp=%b", b, keep_q[b], keep_for(b)); end
    end
    n_cmp++; if (done_it !== last_acc_it + 1) begin n_bad++; $display("FAIL basic_done got=%0d exp=%0d", done_it, last_acc_it + 1); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got=%b exp=0", obs_busy); end
  endtask

  task automatic test_backpressure();
    sel = 4;
    set_cfg(5'd3, 64'd1000, BASE_PERIOD, 64'd100, 32'd3, 16'd1);
    build_expected(64'd1000, BASE_PERIOD, 64'd100, 3, 16'd1);
    pulse_start();
    collect(2, 60);
    n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL bp_hold got=%0d changes exp=0", held_bad); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL bp_tag%0d got=%0d/%b exp=%0d/%b", i, got_q[i].t, got_q[i].r, exp_q[i].t, exp_q[i].r); end
    end
    n_cmp++; if (last_acc_it - first_valid_it < 6) begin n_bad++; $display("FAIL bp_stall got=%0d cycles exp>=6", last_acc_it - first_valid_it); end
    n_cmp++; if (done_it !== last_acc_it + 1) begin n_bad++; $display("FAIL bp_done got=%0d exp=%0d", done_it, last_acc_it + 1); end
  endtask

  task automatic test_flush();
    int waited;
    sel = 3;
    set_cfg(5'd3, 64'd1000, BASE_PERIOD, 64'd100, 32'd0, 16'd1);
    build_expected(64'd1000, BASE_PERIOD, 64'd100, 2, 16'd1);
    tready = 1'b0;
    pulse_start();
    waited = 0;
    while (obs_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++; if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL flush_wait got=%b exp=1", obs_valid); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    collect(0, 60);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL flush_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL flush_tag%0d got=%0d/%b exp=%0d/%b", i, got_q[i].t, got_q[i].r, exp_q[i].t, exp_q[i].r); end
    end
    for (int b = 0; b < keep_q.size(); b++) begin
      n_cmp++; if (keep_q[b] !== keep_for(b)) begin n_bad++; $display("FAIL flush_tkeep%0d got=%b exp=%b", b, keep_q[b], keep_for(b)); end
    end
    n_cmp++; if (done_it !== last_acc_it + 1) begin n_bad++; $display("FAIL flush_done got=%0d exp=%0d", done_it, last_acc_it + 1); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b exp=0", obs_busy); end
  endtask

  task automatic test_reject();
    int seen;
    sel = 4;
    for (int k = 0; k < 2; k++) begin
      set_cfg(5'd3, 64'd1000, 64'd300, (k == 0) ? 64'd300 : 64'd0, 32'd3, 16'd1);
      pulse_start();
      n_cmp++; if (obs_err !== 1'b1 || obs_busy !== 1'b0) begin
        n_bad++; $display("FAIL reject%0d_status got=err%b busy%b exp=err1 busy0", k, obs_err, obs_busy); end
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (obs_valid) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL reject%0d_tvalid got=%0d exp=0", k, seen); end
    end
    set_cfg(5'd7, 64'd5000, BASE_PERIOD, 64'd100, 32'd2, 16'd1);
    build_expected(64'd5000, BASE_PERIOD, 64'd100, 2, 16'd1);
    pulse_start();
    n_cmp++; if (obs_err !== 1'b0 || obs_busy !== 1'b1) begin
      n_bad++; $display("FAIL reject_clear got=err%b busy%b exp=err0 busy1", obs_err, obs_busy); end
    collect(1, 100);
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL reject_rerun_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL reject_rerun_tag%0d got=%0d/%b exp=%0d/%b", i, got_q[i].t, got_q[i].r, exp_q[i].t, exp_q[i].r); end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] st;
    sel = 4;
    st = 64'h0 - (WRAP_PERIOD + 64'd50);
    set_cfg(5'd1, st, WRAP_PERIOD, 64'd50, 32'd2, 16'd1);
    build_expected(st, WRAP_PERIOD, 64'd50, 2, 16'd1);
    pulse_start();
    collect(0, 60);
    n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL wrap_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL wrap_tag%0d got=%h/%b exp=%h/%b", i, got_q[i].t, got_q[i].r, exp_q[i].t, exp_q[i].r); end
    end
    if (got_q.size() == 4) begin
      n_cmp++; if (!(got_q[3].t < st)) begin n_bad++; $display("FAIL wrap_last got=%h exp<%h", got_q[3].t, st); end
    end
  endtask

  task automatic test_random();
    logic [63:0] st, per, hi;
    int unsigned cnt;
    logic [15:0] seed;
    logic [4:0] ch;
    for (int r = 0; r < 8; r++) begin
      sel  = ($urandom_range(0, 1) == 0) ? 3 : 4;
      hi   = 64'($urandom_range(1, 1000));
      per  = hi + 64'd1 + (64'd1 << JB) + 64'($urandom_range(0, 2000));
      st   = {$urandom, $urandom};
      cnt  = $urandom_range(1, 9);
      seed = 16'($urandom);
      ch   = 5'($urandom);
      set_cfg(ch, st, per, hi, 32'(cnt), seed);
      build_expected(st, per, hi, cnt, seed);
      pulse_start();
      collect(1, 400);
      n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand%0d_count got=%0d exp=%0d", r, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
          n_bad++; $display("FAIL rand%0d_tag%0d got=%h/%b/ch%0d exp=%h/%b/ch%0d", r, i, got_q[i].t, got_q[i].r, got_ch_q[i], exp_q[i].t, exp_q[i].r, exp_ch); end
      end
      for (int b = 0; b < keep_q.size(); b++) begin
        n_cmp++; if (keep_q[b] !== keep_for(b)) begin n_bad++; $display("FAIL rand%0d_tkeep%0d got=%b exp=%b", r, b, keep_q[b], keep_for(b)); end
      end
      n_cmp++; if (held_bad !== 0) begin n_bad++; $display("FAIL rand%0d_hold got=%0d exp=0", r, held_bad); end
      n_cmp++; if (done_it !== last_acc_it + 1) begin n_bad++; $display("FAIL rand%0d_done got=%0d exp=%0d", r, done_it, last_acc_it + 1); end
    end
  endtask

  task automatic test_reset_midrun();
    sel = 4;
    set_cfg(5'd3, 64'd1000, BASE_PERIOD, 64'd100, 32'd0, 16'd1);
    tready = 1'b0;
    pulse_start();
    @(negedge clk);
    n_cmp++; if (obs_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got=%b exp=1", obs_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (obs_valid !== 1'b0 || obs_keep !== 4'h0 || obs_busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_drop got=v%b k%h b%b exp=v0 k0 b0", obs_valid, obs_keep, obs_busy); end
    @(negedge clk);
    rst_n = 1'b1; tready = 1'b1;
    @(negedge clk);
    set_cfg(5'd3, 64'd1000, BASE_PERIOD, 64'd100, 32'd3, 16'd1);
    build_expected(64'd1000, BASE_PERIOD, 64'd100, 3, 16'd1);
    pulse_start();
    collect(0, 60);
    n_cmp++; if (first_valid_it !== 1) begin n_bad++; $display("FAIL rstmid_latency got=%0d exp=1", first_valid_it); end
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_ch_q[i] !== exp_ch) begin
        n_bad++; $display("FAIL rstmid_tag%0d got=%0d/%b exp=%0d/%b", i, got_q[i].t, got_q[i].r, exp_q[i].t, exp_q[i].r); end
    end
    for (int b = 0; b < keep_q.size(); b++) begin
      n_cmp++; if (keep_q[b] !== keep_for(b)) begin n_bad++; $display("FAIL rstmid_tkeep%0d got=%b exp=%b", b, keep_q[b], keep_for(b)); end
    end
    n_cmp++; if (done_it !== last_acc_it + 1) begin n_bad++; $display("FAIL rstmid_done got=%0d exp=%0d", done_it, last_acc_it + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_reject();
    test_wrap();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
